// File: rtl/sdram_pkg.sv
// ---------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the SDRAM power-up initialisation sequencer:
//   - SDRAM command encodings {cs_n, ras_n, cas_n, we_n}
//   - A10 precharge-all address constant
//   - 3-bit sequencer state encoding (also what o_state carries when the
//     SDRAM_INIT_STATE_OUT_EN debug port is built in)
//   - max4() helper used to size the shared wait timer
// ---------------------------------------------------------------------------
package sdram_pkg;

    localparam logic [3:0] CMD_INHIBIT   = 4'b1111;
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] CMD_LMR       = 4'b0000;

    localparam logic [12:0] A10_PRECHARGE_ALL = 13'h0400;

    typedef enum logic [2:0] {
        ST_WAIT_PWR  = 3'd0,
        ST_PRECHARGE = 3'd1,
        ST_WAIT_RP   = 3'd2,
        ST_REFRESH   = 3'd3,
        ST_WAIT_RFC  = 3'd4,
        ST_LOAD_MODE = 3'd5,
        ST_WAIT_MRD  = 3'd6,
        ST_DONE      = 3'd7
    } state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sdram_init_timer.sv
// ---------------------------------------------------------------------------
// sdram_init_timer
// Loadable down-counter with a zero flag. Holds at zero until reloaded.
// Ports:
//   clk        - clock, rising edge
//   i_rst      - synchronous active-high reset, counter takes RST_VAL
//   i_load     - load i_load_val this cycle (has priority over counting)
//   i_load_val - value to load
//   o_zero     - counter is zero
// ---------------------------------------------------------------------------
module sdram_init_timer #(
    parameter int             W       = 4,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (i_rst)        r_cnt <= RST_VAL;
        else if (i_load)  r_cnt <= i_load_val;
        else if (!o_zero) r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sdram_init_seq.sv
// ---------------------------------------------------------------------------
// sdram_init_seq
// SDRAM power-up initialisation sequencer: power-up wait, precharge-all,
// N_REFRESH auto-refreshes, load-mode-register, then o_init_done.
// Ports:
//   clk         - clock, rising edge
//   pwr_reset   - synchronous active-high reset
//   o_cke       - clock enable (registered)
//   o_cmd       - {cs_n, ras_n, cas_n, we_n} (registered)
//   o_addr      - address bus, A10 for precharge-all, MODE_REG for LMR
//   o_ba        - bank address, always 0
//   o_init_done - sticky until reset
//   o_state     - registered state, only when SDRAM_INIT_STATE_OUT_EN is
//                 defined (aligned with the command it produced on o_cmd)
// Outputs are a registered decode of the current state, so each command
// appears one cycle after the FSM enters the matching state. The wait timer
// therefore counts from T_x-2 on entry to WAIT_x (the command cycle itself
// is the first clock of the T_x spacing); WAIT_x is skipped when T_x == 1.
// ---------------------------------------------------------------------------
module sdram_init_seq
    import sdram_pkg::*;
#(
    parameter int          T_POWERUP = 10000,
    parameter int          T_RP      = 3,
    parameter int          T_RFC     = 7,
    parameter int          T_MRD     = 2,
    parameter int          N_REFRESH = 8,
    parameter logic [12:0] MODE_REG  = 13'h0030
) (
    input  logic        clk,
    input  logic        pwr_reset,
    output logic        o_cke,
    output logic [3:0]  o_cmd,
    output logic [12:0] o_addr,
    output logic [1:0]  o_ba,
    output logic        o_init_done
`ifdef SDRAM_INIT_STATE_OUT_EN
    ,
    output logic [2:0]  o_state
`endif
);

    localparam int CW_RAW = $clog2(max4(T_POWERUP, T_RP, T_RFC, T_MRD));
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam int RW     = $clog2(N_REFRESH + 1);

    localparam logic [CW-1:0] LD_PWR = CW'(T_POWERUP - 1);
    localparam logic [CW-1:0] LD_RP  = CW'((T_RP  > 1) ? T_RP  - 2 : 0);
    localparam logic [CW-1:0] LD_RFC = CW'((T_RFC > 1) ? T_RFC - 2 : 0);
    localparam logic [CW-1:0] LD_MRD = CW'((T_MRD > 1) ? T_MRD - 2 : 0);

    state_t        r_state;
    state_t        w_next;
    logic          w_load;
    logic [CW-1:0] w_load_val;
    logic          w_zero;
    logic [RW-1:0] r_ref_cnt;
    logic [3:0]    w_cmd;
    logic [12:0]   w_addr;
    logic          w_refs_done;
    logic          w_ref_last;

    sdram_init_timer #(
        .W       (CW),
        .RST_VAL (LD_PWR)
    ) u_timer (
        .clk        (clk),
        .i_rst      (pwr_reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    // w_refs_done: seen from WAIT_RFC (count already includes the last one).
    // w_ref_last: seen from REFRESH (the refresh being issued now is counted).
    assign w_refs_done = (int'(r_ref_cnt) >= N_REFRESH);
    assign w_ref_last  = (int'(r_ref_cnt) + 1 >= N_REFRESH);

    always_ff @(posedge clk) begin
        if (pwr_reset) begin
            r_state   <= ST_WAIT_PWR;
            r_ref_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_REFRESH) r_ref_cnt <= r_ref_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        w_cmd      = CMD_NOP;
        w_addr     = '0;
        case (r_state)
            ST_WAIT_PWR: if (w_zero) w_next = ST_PRECHARGE;
            ST_PRECHARGE: begin
                w_cmd  = CMD_PRECHARGE;
                w_addr = A10_PRECHARGE_ALL;
                if (T_RP == 1) w_next = ST_REFRESH;
                else begin
                    w_next     = ST_WAIT_RP;
                    w_load     = 1'b1;
                    w_load_val = LD_RP;
                end
            end
            ST_WAIT_RP: if (w_zero) w_next = ST_REFRESH;
            ST_REFRESH: begin
                w_cmd = CMD_REFRESH;
                if (T_RFC == 1) w_next = w_ref_last ? ST_LOAD_MODE : ST_REFRESH;
                else begin
                    w_next     = ST_WAIT_RFC;
                    w_load     = 1'b1;
                    w_load_val = LD_RFC;
                end
            end
            ST_WAIT_RFC: if (w_zero) w_next = w_refs_done ? ST_LOAD_MODE : ST_REFRESH;
            ST_LOAD_MODE: begin
                w_cmd  = CMD_LMR;
                w_addr = MODE_REG;
                if (T_MRD == 1) w_next = ST_DONE;
                else begin
                    w_next     = ST_WAIT_MRD;
                    w_load     = 1'b1;
                    w_load_val = LD_MRD;
                end
            end
            ST_WAIT_MRD: if (w_zero) w_next = ST_DONE;
            ST_DONE:     w_next = ST_DONE;
            default:     w_next = ST_WAIT_PWR;
        endcase
    end

    // Output pad registers; reset wins so no partial command escapes.
    always_ff @(posedge clk) begin
        if (pwr_reset) begin
            o_cke       <= 1'b0;
            o_cmd       <= CMD_INHIBIT;
            o_addr      <= '0;
            o_ba        <= 2'b00;
            o_init_done <= 1'b0;
`ifdef SDRAM_INIT_STATE_OUT_EN
            o_state     <= ST_WAIT_PWR;
`endif
        end else begin
            o_cke       <= 1'b1;
            o_cmd       <= w_cmd;
            o_addr      <= w_addr;
            o_ba        <= 2'b00;
            o_init_done <= (r_state == ST_DONE);
`ifdef SDRAM_INIT_STATE_OUT_EN
            o_state     <= r_state;
`endif
        end
    end

endmodule

// File: tb/tb_sdram_init_seq.sv
// ---------------------------------------------------------------------------
// tb_sdram_init_seq
// Two sequencers share one reset: u_a with the nominal test parameters and
// u_b with minimum spacing. A timeline model computes the expected outputs
// for each cycle since reset release. Reset is driven by a directed prefix
// (reset hold, full run, mid-sequence reset at cycle 25) followed by random
// reset pulses.
// ---------------------------------------------------------------------------
module tb_sdram_init_seq;
    import sdram_pkg::*;

    localparam int          TP   = 20;
    localparam logic [12:0] MODE = 13'h0030;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_cke, b_cke, a_done, b_done;
    logic [3:0]  a_cmd, b_cmd;
    logic [12:0] a_addr, b_addr;
    logic [1:0]  a_ba, b_ba;
`ifdef SDRAM_INIT_STATE_OUT_EN
    logic [2:0]  a_st, b_st;
`endif

    sdram_init_seq #(.T_POWERUP(TP), .T_RP(3), .T_RFC(5), .T_MRD(2),
                     .N_REFRESH(2), .MODE_REG(MODE)) u_a (
        .clk(clk), .pwr_reset(rst), .o_cke(a_cke), .o_cmd(a_cmd),
        .o_addr(a_addr), .o_ba(a_ba), .o_init_done(a_done)
`ifdef SDRAM_INIT_STATE_OUT_EN
        , .o_state(a_st)
`endif
    );

    sdram_init_seq #(.T_POWERUP(TP), .T_RP(1), .T_RFC(1), .T_MRD(1),
                     .N_REFRESH(1), .MODE_REG(MODE)) u_b (
        .clk(clk), .pwr_reset(rst), .o_cke(b_cke), .o_cmd(b_cmd),
        .o_addr(b_addr), .o_ba(b_ba), .o_init_done(b_done)
`ifdef SDRAM_INIT_STATE_OUT_EN
        , .o_state(b_st)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t obs=%0h exp=%0h", tag, $time, obs, exp);
        end
    endtask

    // Timeline model: command schedule straight from the cycle formulas.
    function automatic logic [3:0] m_cmd(input int c, input int trp, input int trfc,
                                         input int nref);
        int r0;
        r0 = TP + trp;
        if (c == TP) return CMD_PRECHARGE;
        for (int k = 0; k < nref; k++)
            if (c == r0 + k * trfc) return CMD_REFRESH;
        if (c == r0 + nref * trfc) return CMD_LMR;
        return CMD_NOP;
    endfunction

    function automatic logic [12:0] m_addr(input logic [3:0] cmd);
        if (cmd == CMD_PRECHARGE) return 13'h0400;
        if (cmd == CMD_LMR)       return MODE;
        return 13'h0000;
    endfunction

    function automatic int m_done_cyc(input int trp, input int trfc, input int nref,
                                      input int tmrd);
        return TP + trp + nref * trfc + tmrd;
    endfunction

    function automatic logic [2:0] m_state(input int c, input int trp, input int trfc,
                                           input int nref, input int tmrd);
        int r0, lmr;
        r0  = TP + trp;
        lmr = r0 + nref * trfc;
        if (c < TP)          return ST_WAIT_PWR;
        if (c == TP)         return ST_PRECHARGE;
        if (c < r0)          return ST_WAIT_RP;
        if (c >= lmr + tmrd) return ST_DONE;
        if (c == lmr)        return ST_LOAD_MODE;
        if (c > lmr)         return ST_WAIT_MRD;
        if ((c - r0) % trfc == 0) return ST_REFRESH;
        return ST_WAIT_RFC;
    endfunction

    // Monitor: samples 1 time unit after each rising edge.
    int         cyc = 0;
    int         n_pre = 0, n_ref = 0, n_lmr = 0, n_oth = 0;
    logic       rs;
    logic [3:0] ea, eb;

    always @(posedge clk) begin
        rs = rst;
        #1;
        if (rs) begin
            chk("rst_cke_a",  a_cke,  1'b0);
            chk("rst_cmd_a",  a_cmd,  CMD_INHIBIT);
            chk("rst_addr_a", a_addr, 13'h0);
            chk("rst_done_a", a_done, 1'b0);
            chk("rst_cmd_b",  b_cmd,  CMD_INHIBIT);
            chk("rst_cke_b",  b_cke,  1'b0);
            chk("rst_done_b", b_done, 1'b0);
`ifdef SDRAM_INIT_STATE_OUT_EN
            chk("rst_state_a", a_st, ST_WAIT_PWR);
`endif
            cyc   = 0;
            n_pre = 0; n_ref = 0; n_lmr = 0; n_oth = 0;
        end else begin
            ea = m_cmd(cyc, 3, 5, 2);
            eb = m_cmd(cyc, 1, 1, 1);
            chk("cke_a",  a_cke,  1'b1);
            chk("cmd_a",  a_cmd,  ea);
            chk("addr_a", a_addr, m_addr(ea));
            chk("ba_a",   a_ba,   2'b00);
            chk("done_a", a_done, cyc >= m_done_cyc(3, 5, 2, 2));
            chk("cke_b",  b_cke,  1'b1);
            chk("cmd_b",  b_cmd,  eb);
            chk("addr_b", b_addr, m_addr(eb));
            chk("ba_b",   b_ba,   2'b00);
            chk("done_b", b_done, cyc >= m_done_cyc(1, 1, 1, 1));
`ifdef SDRAM_INIT_STATE_OUT_EN
            chk("state_a", a_st, m_state(cyc, 3, 5, 2, 2));
            chk("state_b", b_st, m_state(cyc, 1, 1, 1, 1));
`endif
            case (a_cmd)
                CMD_PRECHARGE: n_pre++;
                CMD_REFRESH:   n_ref++;
                CMD_LMR:       n_lmr++;
                CMD_NOP:       ;
                default:       n_oth++;
            endcase
            if (cyc == 199) begin
                chk("cnt_pre", n_pre, 1);
                chk("cnt_ref", n_ref, 2);
                chk("cnt_lmr", n_lmr, 1);
                chk("cnt_oth", n_oth, 0);
            end
            cyc++;
        end
    end

    task automatic hold(input logic v, input int n);
        rst = v;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        hold(1'b1, 5);      // reset values
        hold(1'b0, 200);    // full nominal run and command count
        hold(1'b1, 2);
        hold(1'b0, 25);     // reset lands at cycle 25, mid refresh spacing
        hold(1'b1, 2);
        hold(1'b0, 60);     // restart from scratch after mid-sequence reset
        for (int i = 0; i < 10; i++) begin
            hold(1'b1, $urandom_range(1, 3));
            hold(1'b0, $urandom_range(1, 45));
        end
        hold(1'b1, 1);
        hold(1'b0, 50);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
